// File: rtl/speed_frame_arbiter.sv
// speed_frame_arbiter: round-robin framer that serialises NUM_CH captured speed samples onto one byte-wide TX write port.
// Define SPEED_FRAME_CHKSUM_EN for 4-byte frames ending in an XOR checksum; otherwise frames are 3 bytes.
module speed_frame_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH_SPEED = 14,
  parameter int DATA_SIZE   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CH-1:0]             req,
  input  logic [NUM_CH*WIDTH_SPEED-1:0] speed_bus,
  input  logic                          tx_ready,
  input  logic                          clr_overrun,
  output logic                          write,
  output logic [DATA_SIZE-1:0]          data,
  output logic                          busy,
  output logic [3:0]                    grant_id,
  output logic [NUM_CH-1:0]             overrun
);
`ifdef SPEED_FRAME_CHKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [WIDTH_SPEED-1:0] shadow_q [NUM_CH];
  logic [WIDTH_SPEED-1:0] frame_q, sel_shadow;
  logic [NUM_CH-1:0] pending_q, pending_d, overrun_q, overrun_d, grant_oh;
  logic [3:0] grant_q, last_q, pick, cand;
  logic [1:0] idx_q, idx_d;
  logic found;
  logic [2*DATA_SIZE-1:0] frame_ext;
  logic [DATA_SIZE-1:0] b0, b1, b2, cur;
  // Round-robin search starting just after the last granted channel; nearest pending wins.
  always_comb begin
    pick = last_q;
    cand = '0;
    found = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = 4'((int'(last_q) + k) % NUM_CH);
      if (|(pending_q & (NUM_CH'(1) << cand))) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    sel_shadow = '0;
    for (int i = 0; i < NUM_CH; i++) sel_shadow = (pick == 4'(i)) ? shadow_q[i] : sel_shadow;
  end
  // A new request beats the grant-time clear; it is an overrun only if the old sample was not just taken.
  always_comb begin
    grant_oh = (state_q == IDLE && found) ? (NUM_CH'(1) << pick) : '0;
    pending_d = (pending_q & ~grant_oh) | req;
    overrun_d = (clr_overrun ? '0 : overrun_q) | (req & pending_q & ~grant_oh);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      overrun_q <= '0;
      frame_q <= '0;
      grant_q <= '0;
      last_q <= 4'(NUM_CH - 1);
      idx_q <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      idx_q <= idx_d;
      for (int i = 0; i < NUM_CH; i++) if (req[i]) shadow_q[i] <= speed_bus[i*WIDTH_SPEED +: WIDTH_SPEED];
      if (|grant_oh) begin
        frame_q <= sel_shadow;
        grant_q <= pick;
        last_q <= pick;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: begin
        state_d = found ? SEND : IDLE;
        idx_d = found ? 2'd0 : idx_q;
      end
      SEND: state_d = tx_ready ? GAP : SEND;
      GAP: begin
        state_d = (idx_q == LAST_IDX) ? IDLE : SEND;
        idx_d = idx_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    frame_ext = (2*DATA_SIZE)'(frame_q);
    b0 = {4'hA, grant_q};
    b1 = frame_ext[DATA_SIZE-1:0];
    b2 = frame_ext[2*DATA_SIZE-1:DATA_SIZE];
`ifdef SPEED_FRAME_CHKSUM_EN
    cur = idx_q == 2'd0 ? b0 : idx_q == 2'd1 ? b1 : idx_q == 2'd2 ? b2 : b0 ^ b1 ^ b2;
`else
    cur = idx_q == 2'd0 ? b0 : idx_q == 2'd1 ? b1 : b2;
`endif
  end
  always_comb begin
    write = state_q == SEND && tx_ready;
    data = state_q == SEND ? cur : '0;
    busy = state_q != IDLE;
  end
  assign grant_id = grant_q;
  assign overrun = overrun_q;
endmodule

// File: doc/speed_frame_arbiter.md
# speed_frame_arbiter

Shares one byte-wide telemetry output (UART TX FIFO write port) between NUM_CH speed-measurement channels. Captures each channel's speed sample on its done pulse, picks pending channels round-robin, and serialises each sample as a framed byte sequence with write strobes. It sits between the per-motor speed counters and the TX FIFO, and replaces per-channel byte pushers.

## Interface
- NUM_CH, 4: number of speed channels, 2..16.
- WIDTH_SPEED, 14: speed sample width, DATA_SIZE+1..2*DATA_SIZE.
- DATA_SIZE, 8: output byte width; fixed at 8.
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CH  per-channel one-cycle "sample done" pulse.
- speed_bus  in  NUM_CH*WIDTH_SPEED  channel i speed at bits [i*WIDTH_SPEED +: WIDTH_SPEED].
- tx_ready  in  1  downstream can accept a byte this cycle.
- clr_overrun  in  1  one-cycle pulse; clears all overrun flags.
- write  out  1  byte strobe; a byte transfers when write=1.
- data  out  DATA_SIZE  byte being written.
- busy  out  1  high while a frame is in progress (any state except IDLE).
- grant_id  out  4  channel of the current or last frame.
- overrun  out  NUM_CH  sticky; a sample was overwritten before it was sent.

## Operation
- Per channel: a shadow register and a pending flag. When req[i] is high at a clock edge, shadow[i] <= speed_bus slice i and pending[i] <= 1.
- If req[i] arrives while pending[i]=1, the shadow is overwritten with the newest sample and overrun[i] <= 1. The flag stays set until a clr_overrun pulse. If clr_overrun and a new overrun occur in the same cycle, the flag is set.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If any pending bit is set, pick channel g by round-robin.
  - Search starts at the channel after the last grant. After reset the last grant is NUM_CH-1, so channel 0 has highest priority first.
  - Latch the frame bytes from shadow[g], clear pending[g], set grant_id=g, set byte index=0, and go to SEND.
- Frame bytes:
  - B0 = 8'hA0 | g.
  - B1 = shadow[g][7:0].
  - B2 = shadow[g][WIDTH_SPEED-1:8], zero-extended.
  - B3 = B0^B1^B2 (only when checksum is enabled; see Configuration).
- SEND:
  - write = tx_ready (combinational).
  - data = current byte, held stable throughout SEND even while tx_ready=0.
  - When tx_ready=1: the byte transfers and the FSM goes to GAP.
- GAP:
  - write=0, data=0 for exactly one cycle.
  - Then: byte index+1 and back to SEND; or, after the last byte, IDLE.
  - Two write cycles are never back-to-back.
- req[g] arriving during g's own frame sets pending[g] again. It is not an overrun, because pending was cleared at grant. The frame in flight keeps its latched bytes.
- Outside SEND: write=0, data=0.

## Timing
- Reset values: write=0, data=0, busy=0, grant_id=0, overrun=0, all pending=0, state=IDLE. The last-grant pointer resets to NUM_CH-1.
- Reset asserted mid-frame aborts immediately; the partially sent frame is not resumed.
- Latency with tx_ready held high:
  - req[i] high in cycle n → pending visible in n+1 → grant at edge n+1 → first write in cycle n+2.
  - Writes in n+2, n+4, n+6 (and n+8 with checksum).
  - busy falls in cycle n+4+2·(bytes−1).
- Back-to-back frames: IDLE occupies at least one cycle between frames.
- tx_ready low stalls SEND indefinitely. No timeout.
- Simultaneous req on several channels in the same cycle: all are captured; they are granted in round-robin order.

## Configuration
- SPEED_FRAME_CHKSUM_EN defined: 4-byte frame B0..B3, with XOR checksum B3.
- SPEED_FRAME_CHKSUM_EN undefined: 3-byte frame B0..B2; the checksum logic is absent.

## Test plan
- Single req: req[1] with speed 14'h1234, tx_ready=1 → writes 8'hA1, 8'h34, 8'h12, (8'h87 with checksum) on alternate cycles, starting 2 cycles after req.
- Simultaneous req[0] and req[2] after reset → channel 0 frame first, then channel 2; a following req[0]+req[2] pair → channel 0 first again. Pointer is at 2 after the second frame, so 0 wins.
- Backpressure: tx_ready low for 5 cycles during B1 → write stays 0, data held at B1, no byte lost or duplicated.
- Overrun: two req[3] pulses (values 100, then 200) while channel 0 is sending → overrun[3]=1 and channel 3's frame carries 200. clr_overrun → overrun[3]=0.
- reset_n low during B2 → all outputs reset next cycle. After release, a pending-free IDLE shows write=0 and busy=0.
- Self-request: req[2] during channel 2's frame → no overrun, and a second channel 2 frame follows.
